// File: rtl/cpu_b_ram_loader.sv
// Program-load sequencer: copies PROG_LEN ROM bytes into cpu_b RAM256, then releases the CPU.
// Optional LOADER_CHECKSUM_EN adds a modulo-256 sum of the loaded image.
module cpu_b_ram_loader #(
   parameter int unsigned PROG_LEN = 256,
   parameter int unsigned ROM_LAT  = 1,
   parameter int unsigned PULSE_W  = 2
) (
   input  logic       in_clk,
   input  logic       reset,
   input  logic       start,
   output logic [7:0] rom_addr,
   input  logic [7:0] rom_data,
   output logic       loading_ram,
   output logic       set_mar_init,
   output logic [7:0] addr_init,
   output logic       set_ram_init,
   output logic [7:0] instr_from_rom,
   output logic       cpu_reset,
   output logic       done
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic [7:0] checksum,
   output logic       checksum_valid
`endif
);

   typedef enum logic [3:0] {
      StRomRd, StMarSu, StMarSet, StMarHld, StRamSu, StRamSet, StRamHld, StRelease, StDone
   } state_e;

   localparam logic [8:0] LastAddr  = 9'(PROG_LEN - 1);
   localparam logic [2:0] LatLast   = 3'(ROM_LAT - 1);
   localparam logic [2:0] PulseLast = 3'(PULSE_W - 1);

   state_e     state_q, state_d;
   logic [8:0] addr_q, addr_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] data_q, data_d;
   logic [7:0] rom_addr_d, addr_init_d, instr_d;
   logic       loading_d, set_mar_d, set_ram_d, cpu_reset_d, done_d;
   logic       busy, last;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0] sum_d;
`endif

   assign last = (addr_q == LastAddr);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      cnt_d      = '0;
      data_d     = data_q;
      rom_addr_d = rom_addr;
`ifdef LOADER_CHECKSUM_EN
      sum_d      = checksum;
`endif
      unique case (state_q)
         StRomRd: begin
            if (cnt_q == LatLast) begin
               data_d  = rom_data;
               state_d = StMarSu;
`ifdef LOADER_CHECKSUM_EN
               sum_d   = checksum + rom_data;
`endif
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         StMarSu:  state_d = StMarSet;
         StMarSet: begin
            if (cnt_q == PulseLast) state_d = StMarHld;
            else                    cnt_d   = cnt_q + 3'd1;
         end
         StMarHld: state_d = StRamSu;
         StRamSu:  state_d = StRamSet;
         StRamSet: begin
            if (cnt_q == PulseLast) begin
               state_d    = StRamHld;
               // Present the next ROM address during RAM_HLD so the ROM latency
               // overlaps it; park at 0 after the last byte, ready for a reload.
               rom_addr_d = last ? 8'd0 : addr_q[7:0] + 8'd1;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         StRamHld: begin
            if (last) begin
               state_d = StRelease;
            end else begin
               addr_d  = addr_q + 9'd1;
               state_d = StRomRd;
            end
         end
         StRelease: state_d = StDone;
         StDone: begin
            if (start) begin
               state_d    = StRomRd;
               addr_d     = '0;
               rom_addr_d = '0;
`ifdef LOADER_CHECKSUM_EN
               sum_d      = '0;
`endif
            end
         end
         default: state_d = StRomRd;
      endcase

      busy        = !(state_d inside {StRelease, StDone});
      loading_d   = busy;
      cpu_reset_d = (state_d != StDone);
      done_d      = (state_d == StDone);
      set_mar_d   = (state_d == StMarSet);
      set_ram_d   = (state_d == StRamSet);
      addr_init_d = busy ? addr_d[7:0] : 8'd0;
      instr_d     = (busy && state_d != StRomRd) ? data_d : 8'd0;
   end

   always_ff @(posedge in_clk or negedge reset) begin
      if (!reset) begin
         state_q        <= StRomRd;
         addr_q         <= '0;
         cnt_q          <= '0;
         data_q         <= '0;
         rom_addr       <= '0;
         loading_ram    <= 1'b1;
         cpu_reset      <= 1'b1;
         set_mar_init   <= 1'b0;
         set_ram_init   <= 1'b0;
         addr_init      <= '0;
         instr_from_rom <= '0;
         done           <= 1'b0;
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         cnt_q          <= cnt_d;
         data_q         <= data_d;
         rom_addr       <= rom_addr_d;
         loading_ram    <= loading_d;
         cpu_reset      <= cpu_reset_d;
         set_mar_init   <= set_mar_d;
         set_ram_init   <= set_ram_d;
         addr_init      <= addr_init_d;
         instr_from_rom <= instr_d;
         done           <= done_d;
      end
   end

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge in_clk or negedge reset) begin
      if (!reset) begin
         checksum       <= '0;
         checksum_valid <= 1'b0;
      end else begin
         checksum       <= sum_d;
         checksum_valid <= done_d;
      end
   end
`endif

endmodule
